// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
// Holds the parity-mode encodings used by the PARITY parameter, the
// transmitter FSM state type and a parity helper.
// No ports (package).
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_state_t;

  // Callers zero-extend narrower words, so the unused upper bits do not
  // affect the XOR.
  function automatic logic parity_of(input logic [8:0] word, input int mode);
    logic p;
    p = ^word;
    if (mode == PAR_EVEN) begin
      parity_of = p;
    end else if (mode == PAR_ODD) begin
      parity_of = ~p;
    end else begin
      parity_of = 1'b0;
    end
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous holding FIFO in front of the UART transmitter.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   push, push_data     - write request and data (ignored while full)
//   pop                 - read request (ignored while empty); head advances
//   head                - word at the read pointer (valid when !empty)
//   full, empty, count  - occupancy status
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE        = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_r;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_r == FULL_COUNT);
  assign empty   = (count_r == '0);
  assign count   = count_r;
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  // A simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + ONE;
        2'b01:   count_r <= count_r - ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small holding FIFO.
// Frame: start bit (0), DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits (1); every bit lasts CLK_HZ/BAUD_RATE clocks.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   tx_valid    - producer offers tx_data
//   tx_data     - payload word
//   tx_ready    - FIFO can accept a word (low while full or in reset)
//   txd         - registered serial line, idle high
//   tx_busy     - a frame is on the line or words are waiting
//   fifo_count  - current FIFO occupancy
module uart_tx_cfg #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  import uart_pkg::*;

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  tx_state_t              state;
  tx_state_t              state_next;
  logic [CW-1:0]          baud_cnt;
  logic [3:0]             bit_idx;
  logic                   bit_done;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;
  logic                   txd_r;
  logic                   txd_next;
  logic                   ready_en;
  logic                   line_active;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic [DATA_BITS-1:0]   fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;

  // ready_en keeps tx_ready low during reset and lets it rise on the first
  // edge after reset is released.
  assign tx_ready  = ready_en & ~fifo_full;
  assign fifo_push = tx_valid & tx_ready;
  assign bit_done  = (baud_cnt == BAUD_LAST);
  assign txd       = txd_r;
  // txd lags the FSM by one clock, so line_active covers the last stop-bit
  // cycle that is still on the line after the FSM has returned to idle.
  assign tx_busy   = (state != ST_IDLE) | line_active | ~fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // The last stop bit chains straight into the next start bit when a word
  // is waiting, which keeps back-to-back frames gapless.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next = ST_START;
          fifo_pop   = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_done && bit_idx == DATA_LAST)
          state_next = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
      end
      ST_PAR: begin
        if (bit_done) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (bit_done && bit_idx == STOP_LAST) begin
          if (!fifo_empty) begin
            state_next = ST_START;
            fifo_pop   = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Baud and bit counters restart on every state entry, so bit timing
  // never accumulates error from one frame to the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else if (state == ST_IDLE || state_next != state) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else if (bit_done) begin
      baud_cnt <= '0;
      bit_idx  <= bit_idx + 4'd1;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  // The word is captured once on pop; parity is computed from that copy so
  // later FIFO traffic cannot disturb the frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (fifo_pop) begin
      shreg   <= fifo_head;
      par_bit <= parity_of(9'(fifo_head), PARITY);
    end else if (state == ST_DATA && bit_done) begin
      shreg   <= shreg >> 1;
    end
  end

  always_comb begin
    txd_next = 1'b1;
    case (state)
      ST_START: txd_next = 1'b0;
      ST_DATA:  txd_next = shreg[0];
      ST_PAR:   txd_next = par_bit;
      default:  txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txd_r       <= 1'b1;
      ready_en    <= 1'b0;
      line_active <= 1'b0;
    end else begin
      txd_r       <= txd_next;
      ready_en    <= 1'b1;
      line_active <= (state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg with CLKS_PER_BIT = 16.
// Three lanes run side by side: 8N1, 7E2 and 8O1, each with a 4-deep FIFO.
// Each lane has a frame-level model (word queue plus a per-cycle line
// queue) and a compare process; directed sections pin the model with
// hand-computed literal values.
module tb_uart_tx_cfg;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       valid_v = '0;
  logic [2:0][8:0]  data_v = '0;
  logic [2:0]       ready_v;
  logic [2:0]       txd_v;
  logic [2:0]       busy_v;
  logic [2:0][2:0]  cnt_v;
  bit               checking = 1'b0;
  int               n_cmp = 0;
  int               n_bad = 0;

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int lane, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s lane%0d: got %0d expected %0d at %0t", name, lane, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int DB = (g == 1) ? 7 : 8;
    localparam int PR = g;
    localparam int SB = (g == 1) ? 2 : 1;
    localparam int FRAME_CLKS = (1 + DB + ((PR != 0) ? 1 : 0) + SB) * CPB;

    uart_tx_cfg #(
      .CLK_HZ     (16),
      .BAUD_RATE  (1),
      .DATA_BITS  (DB),
      .PARITY     (PR),
      .STOP_BITS  (SB),
      .FIFO_DEPTH (DEPTH)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_valid   (valid_v[g]),
      .tx_data    (data_v[g][DB-1:0]),
      .tx_ready   (ready_v[g]),
      .txd        (txd_v[g]),
      .tx_busy    (busy_v[g]),
      .fifo_count (cnt_v[g])
    );

    int q[$];
    bit line_q[$];
    int rem = 0;
    bit showing = 1'b0;
    bit rdy_en = 1'b0;
    bit exp_txd = 1'b1;

    function automatic void add_bit(input bit v);
      for (int i = 0; i < CPB; i++) line_q.push_back(v);
    endfunction

    // Model: a popped word becomes a list of line levels that appear on txd
    // starting one edge after the pop; a new pop is allowed once the
    // previous frame's length in clocks has elapsed.
    initial begin : model
      int word;
      bit accept;
      bit par;
      forever begin
        @(posedge clk);
        if (rst) begin
          q.delete();
          line_q.delete();
          rem = 0;
          showing = 1'b0;
          rdy_en = 1'b0;
          exp_txd = 1'b1;
        end else begin
          accept = valid_v[g] && rdy_en && (q.size() < DEPTH);
          showing = (line_q.size() > 0);
          exp_txd = showing ? line_q.pop_front() : 1'b1;
          if (rem > 0) rem--;
          if (rem == 0 && q.size() > 0) begin
            word = q.pop_front();
            add_bit(1'b0);
            par = (PR == 2);
            for (int i = 0; i < DB; i++) begin
              add_bit(word[i]);
              par ^= word[i];
            end
            if (PR != 0) add_bit(par);
            for (int i = 0; i < SB; i++) add_bit(1'b1);
            rem = FRAME_CLKS;
          end
          if (accept) q.push_back(int'(data_v[g]) & ((1 << DB) - 1));
          rdy_en = 1'b1;
        end
      end
    end

    initial begin : compare
      forever begin
        @(negedge clk);
        if (checking) begin
          check_output("txd", g, int'(txd_v[g]), int'(exp_txd));
          check_output("tx_ready", g, int'(ready_v[g]), int'(rdy_en && q.size() < DEPTH));
          check_output("tx_busy", g, int'(busy_v[g]), int'((rem > 0) || showing || (q.size() > 0)));
          check_output("fifo_count", g, int'(cnt_v[g]), q.size());
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [2:0] v, input logic [8:0] d0, input logic [8:0] d1, input logic [8:0] d2);
    valid_v   = v;
    data_v[0] = d0;
    data_v[1] = d1;
    data_v[2] = d2;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (busy_v == 3'b000) break;
      @(negedge clk);
    end
    check_output("drain_busy", 0, int'(busy_v), 0);
  endtask

  int lit_bits [3][11];
  logic [8:0] words [6];

  initial begin
    lit_bits[0] = '{0, 1,0,1,0,0,1,0,1, 1, 1};
    lit_bits[1] = '{0, 1,1,0,0,0,0,0, 0, 1, 1};
    lit_bits[2] = '{0, 0,0,0,0,0,0,0,0, 1, 1};

    repeat (3) @(negedge clk);
    checking = 1'b1;
    for (int g = 0; g < 3; g++) begin
      check_output("rst_txd", g, int'(txd_v[g]), 1);
      check_output("rst_ready", g, int'(ready_v[g]), 0);
      check_output("rst_busy", g, int'(busy_v[g]), 0);
      check_output("rst_count", g, int'(cnt_v[g]), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) check_output("ready_after_rst", g, int'(ready_v[g]), 1);

    // One literal frame per lane: 0xA5 8N1, 0x03 7E2, 0x00 8O1.
    apply_stimulus(3'b111, 9'h0A5, 9'h003, 9'h000);
    @(negedge clk);
    apply_stimulus(3'b000, 9'($urandom), 9'($urandom), 9'($urandom));
    for (int g = 0; g < 3; g++) check_output("count_after_push", g, int'(cnt_v[g]), 1);
    @(negedge clk);
    for (int g = 0; g < 3; g++) check_output("txd_E+1", g, int'(txd_v[g]), 1);
    @(negedge clk);
    for (int g = 0; g < 3; g++) check_output("txd_E+2", g, int'(txd_v[g]), 0);
    repeat (8) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      for (int g = 0; g < 3; g++) check_output($sformatf("frame_bit%0d", k), g, int'(txd_v[g]), lit_bits[g][k]);
      repeat (16) @(negedge clk);
    end
    wait_idle(400);

    // Six back-to-back words on lane 0: full after five accepts.
    for (int i = 0; i < 6; i++) words[i] = 9'($urandom);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(3'b001, words[i], 9'h0, 9'h0);
      @(negedge clk);
    end
    check_output("count_after_5", 0, int'(cnt_v[0]), 4);
    check_output("ready_when_full", 0, int'(ready_v[0]), 0);
    apply_stimulus(3'b001, words[5], 9'h0, 9'h0);
    for (int i = 0; i < 400; i++) begin
      if (ready_v[0]) break;
      @(negedge clk);
    end
    check_output("ready_returns", 0, int'(ready_v[0]), 1);
    @(negedge clk);
    apply_stimulus(3'b000, 9'h0, 9'h0, 9'h0);
    wait_idle(1500);

    // Push on the same edge as the end-of-frame pop with two words queued.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(3'b001, 9'($urandom), 9'h0, 9'h0);
      @(negedge clk);
    end
    apply_stimulus(3'b000, 9'h0, 9'h0, 9'h0);
    repeat (158) @(negedge clk);
    check_output("count_before_pop", 0, int'(cnt_v[0]), 2);
    apply_stimulus(3'b001, 9'($urandom), 9'h0, 9'h0);
    @(negedge clk);
    apply_stimulus(3'b000, 9'h0, 9'h0, 9'h0);
    check_output("count_push_pop", 0, int'(cnt_v[0]), 2);
    wait_idle(1000);

    // Reset 40 cycles into a frame with words still queued.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(3'b111, 9'($urandom), 9'($urandom), 9'($urandom));
      @(negedge clk);
    end
    apply_stimulus(3'b000, 9'h0, 9'h0, 9'h0);
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check_output("abort_txd", g, int'(txd_v[g]), 1);
      check_output("abort_count", g, int'(cnt_v[g]), 0);
      check_output("abort_busy", g, int'(busy_v[g]), 0);
    end
    rst = 1'b0;
    repeat (200) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check_output("no_residual_txd", g, int'(txd_v[g]), 1);
      check_output("no_residual_busy", g, int'(busy_v[g]), 0);
    end

    // Random traffic alternating sparse and dense phases, one reset inside.
    for (int cyc = 0; cyc < 6000; cyc++) begin
      for (int g = 0; g < 3; g++) begin
        valid_v[g] = ($urandom_range(0, 99) < (((cyc / 1000) % 2 == 1) ? 60 : 3));
        data_v[g]  = 9'($urandom);
      end
      if (cyc == 3000) rst = 1'b1;
      if (cyc == 3002) rst = 1'b0;
      @(negedge clk);
    end
    apply_stimulus(3'b000, 9'h0, 9'h0, 9'h0);
    wait_idle(3000);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
